// File: rtl/fb_pkg.sv
// Shared types and constants for the FlexBus peripheral register controller:
// FSM state encoding, register word offsets and the base-address mask.
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FB_ADDR,
    FB_WR,
    FB_RD,
    FB_RD_DRV,
    FB_END,
    INT_SVC,
    INT_DONE
  } fb_state_e;

  localparam logic [31:0] FB_BASE_MASK = 32'hF000_0000;

  localparam logic [7:0] LED_FREQ  = 8'h00;
  localparam logic [7:0] BZ_FREQ   = 8'h04;
  localparam logic [7:0] LEDR_PUTY = 8'h08;
  localparam logic [7:0] LEDG_PUTY = 8'h0C;
  localparam logic [7:0] LEDB_PUTY = 8'h10;

endpackage

// File: rtl/fb_addr_decode.sv
// Combinational FlexBus address decode: base-region hit, in-range word-aligned
// offset check and bank word index.
module fb_addr_decode
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h6000_0000,
  parameter int          REG_NUM = 5
) (
  input  logic [31:0] addr,
  output logic        base_hit,
  output logic        valid,
  output logic [2:0]  idx
);

  always_comb begin
    base_hit = (addr & FB_BASE_MASK) == (FB_BASE & FB_BASE_MASK);
    valid    = ({4'b0, addr[27:0]} < 32'(REG_NUM * 4)) && (addr[1:0] == 2'b00);
    idx      = addr[4:2];
  end

endmodule

// File: rtl/fb_bus_ctrl.sv
// FlexBus cycle sequencer and register-bank arbiter (FlexBus host vs one internal
// requester). Optional address-to-completion watchdog: define FB_TIMEOUT_EN.
module fb_bus_ctrl
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE     = 32'h6000_0000,
  parameter int          REG_NUM     = 5,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FB_ALE,
  input  logic        FB_CS,
  input  logic        FB_RW,
  input  logic [31:0] FB_AD_in,
  output logic [31:0] FB_AD_out,
  output logic        FB_AD_oe,
  output logic        FB_TA_n,
  input  logic        INT_REQ,
  input  logic        INT_WE,
  input  logic [2:0]  INT_IDX,
  input  logic [31:0] INT_WDATA,
  output logic        INT_ACK,
  output logic [31:0] INT_RDATA,
  output logic [2:0]  REG_IDX,
  output logic        REG_WE,
  output logic        REG_RE,
  output logic [31:0] REG_WDATA,
  input  logic [31:0] REG_RDATA,
  output logic        FB_ERR,
  output logic [2:0]  dbg_state
);

  // Internal handshake: the requester holds INT_REQ and its command fields
  // stable until it sees the one-cycle INT_ACK; a REQ still high afterwards
  // is a new request.

  fb_state_e   state_q, state_d;
  logic        fb_pend_q, fb_pend_d;
  logic        addr_valid_q, addr_valid_d;
  logic [2:0]  addr_idx_q, addr_idx_d;
  logic        acc_valid_q, acc_valid_d;
  logic        acc_rd_q, acc_rd_d;
  logic [2:0]  reg_idx_q, reg_idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        int_we_q, int_we_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] int_rdata_q, int_rdata_d;

  logic        dec_hit, dec_valid;
  logic [2:0]  dec_idx;
  logic        tmo_hit;

  fb_addr_decode #(
    .FB_BASE (FB_BASE),
    .REG_NUM (REG_NUM)
  ) u_decode (
    .addr     (FB_AD_in),
    .base_hit (dec_hit),
    .valid    (dec_valid),
    .idx      (dec_idx)
  );

`ifdef FB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = ((state_q == FB_ADDR) || (state_q == FB_END)) &&
                   (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q | tmo_hit;
    if ((state_q == FB_ADDR) || (state_q == FB_END)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else if ((state_q == IDLE) || (state_q == INT_SVC) || (state_q == INT_DONE)) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign FB_ERR = err_q;
`else
  assign tmo_hit = 1'b0;
  assign FB_ERR  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    fb_pend_d    = fb_pend_q;
    addr_valid_d = addr_valid_q;
    addr_idx_d   = addr_idx_q;
    acc_valid_d  = acc_valid_q;
    acc_rd_d     = acc_rd_q;
    reg_idx_d    = reg_idx_q;
    wdata_d      = wdata_q;
    int_we_d     = int_we_q;
    rd_data_d    = rd_data_q;
    int_rdata_d  = int_rdata_q;

    // The address register holds the decoded form of the latched address.
    if (FB_ALE) begin
      fb_pend_d    = dec_hit;
      addr_valid_d = dec_valid;
      addr_idx_d   = dec_idx;
    end else if ((state_q == FB_END) && FB_CS) begin
      fb_pend_d = 1'b0;
    end
    if (tmo_hit) begin
      fb_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fb_pend_d) begin
          state_d = FB_ADDR;
        end else if (INT_REQ) begin
          state_d   = INT_SVC;
          int_we_d  = INT_WE;
          reg_idx_d = INT_IDX;
          wdata_d   = INT_WDATA;
        end
      end
      FB_ADDR: begin
        if (!fb_pend_d) begin
          state_d = IDLE;
        end else if (!FB_ALE && !FB_CS) begin
          acc_valid_d = addr_valid_q;
          acc_rd_d    = FB_RW;
          reg_idx_d   = addr_idx_q;
          if (FB_RW) begin
            state_d = FB_RD;
          end else begin
            state_d = FB_WR;
            wdata_d = FB_AD_in;
          end
        end
      end
      FB_WR:     state_d = FB_END;
      FB_RD:     state_d = FB_RD_DRV;
      FB_RD_DRV: begin
        rd_data_d = acc_valid_q ? REG_RDATA : 32'h0;
        state_d   = FB_END;
      end
      FB_END: begin
        if (FB_CS || tmo_hit) begin
          state_d = IDLE;
        end
      end
      INT_SVC:   state_d = INT_DONE;
      INT_DONE: begin
        if (!int_we_q) begin
          int_rdata_d = REG_RDATA;
        end
        state_d = fb_pend_d ? FB_ADDR : IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      fb_pend_q    <= 1'b0;
      addr_valid_q <= 1'b0;
      addr_idx_q   <= 3'd0;
      acc_valid_q  <= 1'b0;
      acc_rd_q     <= 1'b0;
      reg_idx_q    <= 3'd0;
      wdata_q      <= 32'h0;
      int_we_q     <= 1'b0;
      rd_data_q    <= 32'h0;
      int_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      fb_pend_q    <= fb_pend_d;
      addr_valid_q <= addr_valid_d;
      addr_idx_q   <= addr_idx_d;
      acc_valid_q  <= acc_valid_d;
      acc_rd_q     <= acc_rd_d;
      reg_idx_q    <= reg_idx_d;
      wdata_q      <= wdata_d;
      int_we_q     <= int_we_d;
      rd_data_q    <= rd_data_d;
      int_rdata_q  <= int_rdata_d;
    end
  end

  // Outputs decode only state and registered data, never FB_* inputs.
  always_comb begin
    FB_TA_n   = !((state_q == FB_WR) || (state_q == FB_RD_DRV));
    FB_AD_oe  = (state_q == FB_RD_DRV) || ((state_q == FB_END) && acc_rd_q);
    FB_AD_out = 32'h0;
    if (state_q == FB_RD_DRV) begin
      FB_AD_out = acc_valid_q ? REG_RDATA : 32'h0;
    end else if ((state_q == FB_END) && acc_rd_q) begin
      FB_AD_out = rd_data_q;
    end
    REG_WE    = ((state_q == FB_WR) && acc_valid_q) || ((state_q == INT_SVC) && int_we_q);
    REG_RE    = ((state_q == FB_RD) && acc_valid_q) || ((state_q == INT_SVC) && !int_we_q);
    REG_IDX   = reg_idx_q;
    REG_WDATA = wdata_q;
    INT_ACK   = (state_q == INT_DONE);
    INT_RDATA = ((state_q == INT_DONE) && !int_we_q) ? REG_RDATA : int_rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_fb_bus_ctrl.sv
// Self-checking bench for fb_bus_ctrl: FlexBus and internal drivers, a register
// bank model, and scoreboards for bank writes, FlexBus reads and INT reads.
module tb_fb_bus_ctrl;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fb_ale, fb_cs, fb_rw;
  logic [31:0] fb_ad_in, fb_ad_out;
  logic        fb_ad_oe, fb_ta_n;
  logic        int_req, int_we;
  logic [2:0]  int_idx;
  logic [31:0] int_wdata, int_rdata;
  logic        int_ack;
  logic [2:0]  reg_idx;
  logic        reg_we, reg_re;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        fb_err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  fb_bus_ctrl #(
    .FB_BASE     (32'h6000_0000),
    .REG_NUM     (5),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .FB_ALE    (fb_ale),
    .FB_CS     (fb_cs),
    .FB_RW     (fb_rw),
    .FB_AD_in  (fb_ad_in),
    .FB_AD_out (fb_ad_out),
    .FB_AD_oe  (fb_ad_oe),
    .FB_TA_n   (fb_ta_n),
    .INT_REQ   (int_req),
    .INT_WE    (int_we),
    .INT_IDX   (int_idx),
    .INT_WDATA (int_wdata),
    .INT_ACK   (int_ack),
    .INT_RDATA (int_rdata),
    .REG_IDX   (reg_idx),
    .REG_WE    (reg_we),
    .REG_RE    (reg_re),
    .REG_WDATA (reg_wdata),
    .REG_RDATA (reg_rdata),
    .FB_ERR    (fb_err),
    .dbg_state (dbg_state)
  );

  // Register bank: synchronous write, one-cycle read latency.
  logic [31:0] mem [8];
  always @(posedge clk) begin
    if (reg_we === 1'b1) mem[reg_idx] <= reg_wdata;
    if (reg_re === 1'b1) reg_rdata <= mem[reg_idx];
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [34:0] exp_wr_q[$];
  logic [32:0] exp_int_q[$];
  logic [31:0] sh [8];
  int          re_cnt = 0;
  int          ta_cnt = 0;
  logic        prev_ta_low = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (reg_re === 1'b1) re_cnt++;
    if (fb_ta_n === 1'b0) begin
      ta_cnt++;
      if (prev_ta_low) chk("ta_one_cycle", fb_ta_n, 1'b1);
      if (fb_ad_oe === 1'b1) begin
        if (exp_q.size() == 0) chk("rd_unexpected_oe", fb_ad_oe, 1'b0);
        else chk("fb_rdata", fb_ad_out, exp_q.pop_front());
      end
    end
    prev_ta_low = (fb_ta_n === 1'b0);
    if (reg_we === 1'b1) begin
      if (exp_wr_q.size() == 0) chk("wr_unexpected", reg_we, 1'b0);
      else chk("bank_write", {reg_idx, reg_wdata}, exp_wr_q.pop_front());
    end
    if (int_ack === 1'b1) begin
      if (exp_int_q.size() == 0) chk("ack_unexpected", int_ack, 1'b0);
      else begin
        e = exp_int_q.pop_front();
        if (e[32]) chk("int_rdata", int_rdata, e[31:0]);
      end
    end
  end

  task automatic fb_xfer(input logic [31:0] addr, input logic rw, input logic [31:0] data,
                         input int extra);
    logic       hit, ok;
    logic [2:0] idx;
    int         want, lat, re0, ta0;
    hit  = (addr[31:28] == 4'h6);
    ok   = hit && (addr[27:0] < 28'd20) && (addr[1:0] == 2'b00);
    idx  = addr[4:2];
    want = !hit ? -1 : ((rw ? 2 : 1) + extra);
    if (hit) begin
      if (rw) exp_q.push_back(ok ? sh[idx] : 32'h0);
      else if (ok) begin
        exp_wr_q.push_back({idx, data});
        sh[idx] = data;
      end
    end
    @(posedge clk); #1;
    re0 = re_cnt; ta0 = ta_cnt;
    fb_ale = 1'b1; fb_ad_in = addr; fb_rw = rw; fb_cs = 1'b1;
    @(posedge clk); #1;
    fb_ale = 1'b0; fb_cs = 1'b0; fb_ad_in = rw ? 32'h0 : data;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fb_ta_n === 1'b0 && lat < 0) lat = i;
    end
    chk("fb_ta_latency", lat, want);
    chk("fb_oe_in_end", fb_ad_oe, hit && rw);
    @(posedge clk); #1;
    fb_cs = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("fb_oe_after_cs", fb_ad_oe, 1'b0);
    chk("fb_idle_after_cs", dbg_state, IDLE);
    chk("fb_re_count", re_cnt - re0, (hit && rw && ok) ? 1 : 0);
    chk("fb_ta_count", ta_cnt - ta0, hit ? 1 : 0);
  endtask

  task automatic int_xfer(input logic we, input logic [2:0] idx, input logic [31:0] data,
                          output int lat, output time ack_t);
    exp_int_q.push_back({~we, we ? 32'h0 : sh[idx]});
    if (we) begin
      exp_wr_q.push_back({idx, data});
      sh[idx] = data;
    end
    @(posedge clk); #1;
    int_req = 1'b1; int_we = we; int_idx = idx; int_wdata = data;
    lat = -1; ack_t = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int_ack === 1'b1) begin
        lat = i; ack_t = $time;
        break;
      end
    end
    if (lat < 0) chk("int_ack_timeout", int_ack, 1'b1);
    @(posedge clk); #1;
    int_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          lat;
    time         ack_t, fb_end_t;
    logic [31:0] a, d;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 32'h0;
      sh[i]  = 32'h0;
    end
    rst = 1'b1; fb_ale = 1'b0; fb_cs = 1'b1; fb_rw = 1'b0; fb_ad_in = 32'h0;
    int_req = 1'b0; int_we = 1'b0; int_idx = 3'd0; int_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ad_out", fb_ad_out, 32'h0);
    chk("rst_oe", fb_ad_oe, 1'b0);
    chk("rst_ta_n", fb_ta_n, 1'b1);
    chk("rst_int_ack", int_ack, 1'b0);
    chk("rst_int_rdata", int_rdata, 32'h0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_reg_re", reg_re, 1'b0);
    chk("rst_reg_idx", reg_idx, 3'd0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);
    chk("rst_fb_err", fb_err, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;

    // Directed FlexBus cycles: write/read back, foreign base, bad offsets.
    fb_xfer(32'h6000_0000 | 32'(BZ_FREQ), 1'b0, 32'h0000_1234, 0);
    fb_xfer(32'h6000_0000 | 32'(BZ_FREQ), 1'b1, 32'h0, 0);
    fb_xfer(32'h7000_0000, 1'b0, 32'hDEAD_BEEF, 0);
    fb_xfer(32'h7000_0000, 1'b1, 32'h0, 0);
    fb_xfer(32'h6000_0014, 1'b1, 32'h0, 0);
    fb_xfer(32'h6000_0002, 1'b0, 32'h5555_AAAA, 0);
    fb_xfer(32'h6000_0000 | 32'(LEDB_PUTY), 1'b0, 32'hCAFE_0010, 0);
    fb_xfer(32'h6000_0000 | 32'(LEDB_PUTY), 1'b1, 32'h0, 0);

    int_xfer(1'b1, 3'd2, 32'h0BAD_F00D, lat, ack_t);
    chk("int_wr_latency", lat, 2);
    int_xfer(1'b0, 3'd2, 32'h0, lat, ack_t);
    chk("int_rd_latency", lat, 2);

    // INT_REQ and ALE in the same cycle: FlexBus is served first.
    fork
      begin
        fb_xfer(32'h6000_0000 | 32'(LED_FREQ), 1'b1, 32'h0, 0);
        fb_end_t = $time;
      end
      int_xfer(1'b1, 3'd3, 32'h0000_A5A5, lat, ack_t);
    join
    chk("int_after_fb", ack_t > fb_end_t, 1'b1);

    // ALE while the internal access sits in INT_SVC.
    fork
      int_xfer(1'b1, 3'd2, 32'h1357_9BDF, lat, ack_t);
      begin
        @(posedge clk);
        fb_xfer(32'h6000_0000 | 32'(BZ_FREQ), 1'b1, 32'h0, 1);
      end
    join
    chk("int_svc_ale_latency", lat, 2);

    for (int n = 0; n < 24; n++) begin
      a = 32'h6000_0000 | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'h2;
      if ($urandom_range(0, 7) == 0) a = 32'h5000_0000 | a[27:0];
      d = $urandom;
      fb_xfer(a, 1'($urandom_range(0, 1)), d, 0);
      if ($urandom_range(0, 2) == 0) begin
        int_xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), $urandom, lat, ack_t);
        chk("int_rand_latency", lat, 2);
      end
    end

    // Reset while driving read data.
    exp_q.push_back(sh[1]);
    @(posedge clk); #1;
    fb_ale = 1'b1; fb_ad_in = 32'h6000_0004; fb_rw = 1'b1; fb_cs = 1'b1;
    @(posedge clk); #1;
    fb_ale = 1'b0; fb_cs = 1'b0; fb_ad_in = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pre_ta", fb_ta_n, 1'b0);
    chk("rst_mid_pre_state", dbg_state, FB_RD_DRV);
    @(negedge clk); #1;
    chk("rst_mid_oe", fb_ad_oe, 1'b0);
    chk("rst_mid_ta_n", fb_ta_n, 1'b1);
    chk("rst_mid_state", dbg_state, IDLE);
    chk("rst_mid_reg_idx", reg_idx, 3'd0);
    chk("rst_mid_reg_wdata", reg_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; fb_cs = 1'b1;

    fb_xfer(32'h6000_0000 | 32'(LEDG_PUTY), 1'b1, 32'h0, 0);

`ifdef FB_TIMEOUT_EN
    @(posedge clk); #1;
    fb_ale = 1'b1; fb_ad_in = 32'h6000_0000; fb_cs = 1'b1;
    @(posedge clk); #1;
    fb_ale = 1'b0;
    repeat (20) @(negedge clk);
    chk("tmo_err", fb_err, 1'b1);
    chk("tmo_idle", dbg_state, IDLE);
    chk("tmo_no_oe", fb_ad_oe, 1'b0);
`else
    chk("err_tied_low", fb_err, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_wr_q_drained", exp_wr_q.size(), 0);
    chk("exp_int_q_drained", exp_int_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
